// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for an RV32I subset (lw, sw, addi, add, sub).
// Accepts one instruction word at a time and walks it through DECODE/EXEC/MEM/WB.
module datapath_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  output logic        instr_ready,
  output logic        writeEnable_Registers,
  output logic        writeEnable_DataMemory,
  output logic        muxSelect_SumVsReadData,
  output logic        muxSelect_ImmVsDataout2,
  output logic        SumOrSub,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired_count
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} stateT;
  typedef enum logic [2:0] {OP_LW, OP_SW, OP_ADDI, OP_ADD, OP_SUB, OP_BAD} opT;

  function automatic opT decodeOp(input logic [31:0] w);
    opT op;
    op = OP_BAD;
    case (w[6:0])
      7'b0000011: if (w[14:12] == 3'b010) op = OP_LW;
      7'b0100011: if (w[14:12] == 3'b010) op = OP_SW;
      7'b0010011: if (w[14:12] == 3'b000) op = OP_ADDI;
      7'b0110011: begin
        if (w[14:12] == 3'b000 && w[31:25] == 7'b0000000) op = OP_ADD;
        else if (w[14:12] == 3'b000 && w[31:25] == 7'b0100000) op = OP_SUB;
      end
      default: op = OP_BAD;
    endcase
    return op;
  endfunction

  stateT       state;
  logic [31:0] instrReg;
  logic [15:0] retiredCount;
  logic [31:0] decodedImm;
  opT          curOp;
  opT          newOp;

  assign curOp         = decodeOp(instrReg);
  assign newOp         = decodeOp(instruction);
  assign retired_count = retiredCount;

  always_comb begin
    decodedImm = 32'h0;
    case (curOp)
      OP_LW, OP_ADDI: decodedImm = {{20{instrReg[31]}}, instrReg[31:20]};
      OP_SW:          decodedImm = {{20{instrReg[31]}}, instrReg[31:25], instrReg[11:7]};
      default:        decodedImm = 32'h0;
    endcase
  end

  // Outputs are registered, so each state's strobes are set on the edge that enters it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      instrReg                <= 32'h0;
      instr_ready             <= 1'b1;
      writeEnable_Registers   <= 1'b0;
      writeEnable_DataMemory  <= 1'b0;
      muxSelect_SumVsReadData <= 1'b0;
      muxSelect_ImmVsDataout2 <= 1'b0;
      SumOrSub                <= 1'b0;
      rs1                     <= 5'd0;
      rs2                     <= 5'd0;
      rd                      <= 5'd0;
      imm                     <= 32'h0;
      done                    <= 1'b0;
      illegal                 <= 1'b0;
      retiredCount            <= 16'h0;
    end else begin
      writeEnable_Registers   <= 1'b0;
      writeEnable_DataMemory  <= 1'b0;
      muxSelect_SumVsReadData <= 1'b0;
      done                    <= 1'b0;
      illegal                 <= 1'b0;
      if (done) retiredCount <= retiredCount + 16'd1;

      case (state)
        IDLE: begin
          if (instr_valid) begin
            instrReg    <= instruction;
            illegal     <= (newOp == OP_BAD);
            instr_ready <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (curOp == OP_BAD) begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            rs1                     <= instrReg[19:15];
            rs2                     <= instrReg[24:20];
            rd                      <= instrReg[11:7];
            imm                     <= decodedImm;
            muxSelect_ImmVsDataout2 <= (curOp == OP_ADD) || (curOp == OP_SUB);
            SumOrSub                <= (curOp == OP_SUB);
            state                   <= EXEC;
          end
        end
        EXEC: begin
          if (curOp == OP_LW || curOp == OP_SW) begin
            writeEnable_DataMemory <= (curOp == OP_SW);
            done                   <= (curOp == OP_SW);
            state                  <= MEM;
          end else begin
            writeEnable_Registers   <= (rd != 5'd0);
            muxSelect_SumVsReadData <= 1'b1;
            done                    <= 1'b1;
            state                   <= WB;
          end
        end
        MEM: begin
          if (curOp == OP_SW) begin
            muxSelect_ImmVsDataout2 <= 1'b0;
            SumOrSub                <= 1'b0;
            instr_ready             <= 1'b1;
            state                   <= IDLE;
          end else begin
            writeEnable_Registers <= (rd != 5'd0);
            done                  <= 1'b1;
            state                 <= WB;
          end
        end
        WB: begin
          muxSelect_ImmVsDataout2 <= 1'b0;
          SumOrSub                <= 1'b0;
          instr_ready             <= 1'b1;
          state                   <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: stimulus pushes expected retire/illegal
// records, a negedge monitor pops and compares them whenever done or illegal pulses.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        instr_ready;
  logic        writeEnable_Registers;
  logic        writeEnable_DataMemory;
  logic        muxSelect_SumVsReadData;
  logic        muxSelect_ImmVsDataout2;
  logic        SumOrSub;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        done;
  logic        illegal;
  logic [15:0] retired_count;

  datapath_sequencer dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .instr_ready(instr_ready),
    .writeEnable_Registers(writeEnable_Registers),
    .writeEnable_DataMemory(writeEnable_DataMemory),
    .muxSelect_SumVsReadData(muxSelect_SumVsReadData),
    .muxSelect_ImmVsDataout2(muxSelect_ImmVsDataout2),
    .SumOrSub(SumOrSub),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .imm(imm),
    .done(done),
    .illegal(illegal),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isIllegal;
    logic        weReg;
    logic        weMem;
    logic        muxSum;
    logic        muxImm;
    logic        sumOrSub;
    int          rs1;
    int          rs2;
    int          rd;
    logic [31:0] imm;
    int          latency;
    int          acceptCycle;
    logic [15:0] count;
  } expectT;

  expectT      scoreboard[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  logic [15:0] expCount = 16'h0;
  int          addAccept, subAccept, dummyAccept;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic expectT mkExp(input logic isIll, input logic weReg, input logic weMem,
                                   input logic muxSum, input logic muxImm, input logic sumOrSub,
                                   input int r1, input int r2, input int rdx,
                                   input logic [31:0] immx, input int latency);
    expectT e;
    e.isIllegal = isIll;  e.weReg = weReg;   e.weMem = weMem;
    e.muxSum = muxSum;    e.muxImm = muxImm; e.sumOrSub = sumOrSub;
    e.rs1 = r1;           e.rs2 = r2;        e.rd = rdx;
    e.imm = immx;         e.latency = latency;
    e.acceptCycle = 0;    e.count = 16'h0;
    return e;
  endfunction

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readyTimeout", {31'b0, instr_ready}, 32'h1);
  endtask

  task automatic applyStimulus(input logic [31:0] word, input expectT e, output int acceptAt);
    waitReady();
    e.acceptCycle = cycle;
    e.count       = expCount;
    if (!e.isIllegal) expCount = expCount + 16'd1;
    acceptAt    = cycle;
    instr_valid = 1'b1;
    instruction = word;
    scoreboard.push_back(e);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = 32'h0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((scoreboard.size() != 0 || !instr_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainTimeout", scoreboard.size(), 32'h0);
  endtask

  // Per-cycle invariants plus scoreboard comparison on every retire or illegal pulse.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("strobeExclusive", {31'b0, writeEnable_Registers & writeEnable_DataMemory}, 32'h0);
      checkOutput("strobeOnlyWithDone", {31'b0, (writeEnable_Registers | writeEnable_DataMemory) & ~done}, 32'h0);
      checkOutput("idleMuxZero", {31'b0, instr_ready & (muxSelect_SumVsReadData | muxSelect_ImmVsDataout2 | SumOrSub)}, 32'h0);
      if (done || illegal) begin
        if (scoreboard.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedPulse actual done=%0b illegal=%0b required none", done, illegal);
        end else begin
          expectT e;
          e = scoreboard.pop_front();
          checkOutput("latency", cycle - e.acceptCycle, e.latency);
          checkOutput("illegal", {31'b0, illegal}, {31'b0, e.isIllegal});
          checkOutput("done", {31'b0, done}, {31'b0, ~e.isIllegal});
          checkOutput("weReg", {31'b0, writeEnable_Registers}, {31'b0, e.weReg});
          checkOutput("weMem", {31'b0, writeEnable_DataMemory}, {31'b0, e.weMem});
          checkOutput("countAtPulse", {16'b0, retired_count}, {16'b0, e.count});
          if (!e.isIllegal) begin
            checkOutput("muxSumVsRead", {31'b0, muxSelect_SumVsReadData}, {31'b0, e.muxSum});
            checkOutput("muxImmVsD2", {31'b0, muxSelect_ImmVsDataout2}, {31'b0, e.muxImm});
            checkOutput("sumOrSub", {31'b0, SumOrSub}, {31'b0, e.sumOrSub});
            checkOutput("imm", imm, e.imm);
            if (e.rs1 >= 0) checkOutput("rs1", {27'b0, rs1}, e.rs1);
            if (e.rs2 >= 0) checkOutput("rs2", {27'b0, rs2}, e.rs2);
            if (e.rd >= 0)  checkOutput("rd", {27'b0, rd}, e.rd);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with instr_valid held high: the word must not be taken.
    reset       = 1'b1;
    instr_valid = 1'b1;
    instruction = 32'h001101B3;
    repeat (2) @(negedge clk);
    checkOutput("resetStrobes", {25'b0, writeEnable_Registers, writeEnable_DataMemory,
                muxSelect_SumVsReadData, muxSelect_ImmVsDataout2, SumOrSub, done, illegal}, 32'h0);
    checkOutput("resetRegs", {17'b0, rs1, rs2, rd}, 32'h0);
    checkOutput("resetImm", imm, 32'h0);
    checkOutput("resetCount", {16'b0, retired_count}, 32'h0);
    reset       = 1'b0;
    instr_valid = 1'b0;
    instruction = 32'h0;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'b0, instr_ready}, 32'h1);

    applyStimulus(32'h00002083, mkExp(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 4), dummyAccept);          // lw x1,0(x0)
    applyStimulus(32'h001101B3, mkExp(0, 1, 0, 1, 1, 0, 2, 1, 3, 32'h0, 3), addAccept);            // add x3,x2,x1
    applyStimulus(32'h40118233, mkExp(0, 1, 0, 1, 1, 1, 3, 1, 4, 32'h0, 3), subAccept);            // sub x4,x3,x1
    checkOutput("throughputAlu", subAccept - addAccept, 32'd4);
    applyStimulus(32'h00302C23, mkExp(0, 0, 1, 0, 0, 0, 0, 3, -1, 32'd24, 3), dummyAccept);        // sw x3,24(x0)
    applyStimulus(32'hFE512E23, mkExp(0, 0, 1, 0, 0, 0, 2, 5, -1, 32'hFFFFFFFC, 3), dummyAccept);  // sw x5,-4(x2)
    applyStimulus(32'hFFF08393, mkExp(0, 1, 0, 1, 0, 0, 1, -1, 7, 32'hFFFFFFFF, 3), dummyAccept);  // addi x7,x1,-1
    applyStimulus(32'h00100013, mkExp(0, 0, 0, 1, 0, 0, 0, -1, 0, 32'h1, 3), dummyAccept);         // addi x0,x0,1
    applyStimulus(32'h00000000, mkExp(1, 0, 0, 0, 0, 0, -1, -1, -1, 32'h0, 1), dummyAccept);       // all-zero word
    applyStimulus(32'h201101B3, mkExp(1, 0, 0, 0, 0, 0, -1, -1, -1, 32'h0, 1), dummyAccept);       // bad funct7
    applyStimulus(32'h00000083, mkExp(1, 0, 0, 0, 0, 0, -1, -1, -1, 32'h0, 1), dummyAccept);       // lb, unsupported
    applyStimulus(32'h00002083, mkExp(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 4), dummyAccept);          // lw again
    waitDrain();
    @(negedge clk);
    checkOutput("countAfterSequence", {16'b0, retired_count}, {16'b0, expCount});

    // Reset during EXEC of an add abandons it.
    waitReady();
    instr_valid = 1'b1;
    instruction = 32'h001101B3;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortStrobes", {30'b0, writeEnable_Registers, writeEnable_DataMemory}, 32'h0);
    checkOutput("abortDone", {31'b0, done}, 32'h0);
    checkOutput("abortCount", {16'b0, retired_count}, 32'h0);
    checkOutput("abortIdle", {31'b0, instr_ready}, 32'h1);
    reset    = 1'b0;
    expCount = 16'h0;
    @(negedge clk);
    checkOutput("abortStillIdle", {31'b0, instr_ready}, 32'h1);

    // Counter wrap: preload to 0xFFFF, retire one more.
    force dut.retiredCount = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.retiredCount;
    expCount = 16'hFFFF;
    applyStimulus(32'hFFF08393, mkExp(0, 1, 0, 1, 0, 0, 1, -1, 7, 32'hFFFFFFFF, 3), dummyAccept);
    waitDrain();
    @(negedge clk);
    checkOutput("countWrap", {16'b0, retired_count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
